// File: rtl/cond_flag_unit_pkg.sv
// Shared constants for condition evaluation and the NZCV flag register.
// Latency: none (package only).
// Backpressure: not applicable.
//
// Contents: condition-code values, flag bit positions inside {N,Z,C,V},
// and the FlagWrite field layout ([1] selects N,Z; [0] selects C,V).
package cond_flag_unit_pkg;

  // Condition field encodings
  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;
  localparam logic [3:0] COND_NV = 4'b1111;

  // Bit positions inside the 4-bit {N,Z,C,V} flag vector
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  // FlagWrite field encoding: one enable bit per flag pair
  localparam int FW_BIT_NZ = 1;
  localparam int FW_BIT_CV = 0;

endpackage

// File: rtl/cond_flag_unit_if.sv
// Execute-stage control/flag bundle between the pipeline and cond_flag_unit.
// Latency: wires only.
// Backpressure: StallE/FlushE/ValidE carry pipeline hold and squash.
//
// master: pipeline side (drives Execute controls, observes gated results).
// slave : cond_flag_unit side.
interface cond_flag_unit_if;
  logic       ValidE;
  logic       StallE;
  logic       FlushE;
  logic [3:0] CondE;
  logic [1:0] FlagWriteE;
  logic [3:0] ALUFlags;
  logic       PCSrcE;
  logic       RegWriteE;
  logic       MemWriteE;

  logic [3:0] Flags;
  logic       CarryOut;
  logic       CondExE;
  logic       PCSrcGE;
  logic       RegWriteGE;
  logic       MemWriteGE;
  logic       PCSrcM;
  logic       RegWriteM;
  logic       MemWriteM;
  logic       CondExM;

  modport master (
    output ValidE, StallE, FlushE, CondE, FlagWriteE, ALUFlags,
           PCSrcE, RegWriteE, MemWriteE,
    input  Flags, CarryOut, CondExE, PCSrcGE, RegWriteGE, MemWriteGE,
           PCSrcM, RegWriteM, MemWriteM, CondExM
  );

  modport slave (
    input  ValidE, StallE, FlushE, CondE, FlagWriteE, ALUFlags,
           PCSrcE, RegWriteE, MemWriteE,
    output Flags, CarryOut, CondExE, PCSrcGE, RegWriteGE, MemWriteGE,
           PCSrcM, RegWriteM, MemWriteM, CondExM
  );
endinterface

// File: rtl/cond_flag_unit_cond_check.sv
// Evaluates a 4-bit condition field against an {N,Z,C,V} flag vector.
// Latency: combinational.
// Backpressure: none.
//
// Ports: cond (condition field), flags ({N,Z,C,V}), cond_ex (condition passes).
// NEVER_ON_1111 selects whether 4'b1111 is "never" (1) or "always" (0).
module cond_check
  import cond_flag_unit_pkg::*;
#(
  parameter int NEVER_ON_1111 = 1
) (
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       cond_ex
);

  logic n, z, c, v;

  assign n = flags[FLAG_N];
  assign z = flags[FLAG_Z];
  assign c = flags[FLAG_C];
  assign v = flags[FLAG_V];

  always_comb begin
    cond_ex = 1'b0;
    case (cond)
      COND_EQ: cond_ex = z;
      COND_NE: cond_ex = !z;
      COND_CS: cond_ex = c;
      COND_CC: cond_ex = !c;
      COND_MI: cond_ex = n;
      COND_PL: cond_ex = !n;
      COND_VS: cond_ex = v;
      COND_VC: cond_ex = !v;
      COND_HI: cond_ex = c & !z;
      COND_LS: cond_ex = !c | z;
      COND_GE: cond_ex = (n == v);
      COND_LT: cond_ex = (n != v);
      COND_GT: cond_ex = !z & (n == v);
      COND_LE: cond_ex = z | (n != v);
      COND_AL: cond_ex = 1'b1;
      COND_NV: cond_ex = (NEVER_ON_1111 == 0);
      default: cond_ex = 1'b0;
    endcase
  end

endmodule

// File: rtl/cond_flag_unit.sv
// Holds NZCV, evaluates the Execute condition, gates side effects into Memory.
// Latency: gated controls combinational; Flags and M-stage copies 1 cycle.
// Backpressure: StallE holds flags and injects a bubble; FlushE squashes.
//
// Ports: clk, reset (sync, active-low), bus (cond_flag_unit_if.slave).
// Optional COND_PERF_CNT_EN adds ExecCnt / SquashCnt (CNT_W bits, wrapping).
module cond_flag_unit
  import cond_flag_unit_pkg::*;
#(
  parameter int NEVER_ON_1111 = 1,
  parameter int CNT_W         = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  cond_flag_unit_if.slave      bus
`ifdef COND_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]     ExecCnt,
  output logic [CNT_W-1:0]     SquashCnt
`endif
);

  logic [3:0] flags_q;
  logic       cond_ex;
  logic       live;       // real, unstalled, unsquashed instruction
  logic       go;
  logic       gate;
  logic       bubble;
  logic       pcsrc_m_q, regwrite_m_q, memwrite_m_q, condex_m_q;

  // Condition is evaluated on the registered flags only, so a flag writer's
  // result reaches the next instruction through flags_q, one cycle later.
  cond_check #(.NEVER_ON_1111(NEVER_ON_1111)) u_cond_check (
    .cond    (bus.CondE),
    .flags   (flags_q),
    .cond_ex (cond_ex)
  );

  assign live   = bus.ValidE & !bus.StallE & !bus.FlushE;
  assign go     = live & cond_ex;
  // Gated controls are not masked by StallE; the M register bubble covers it.
  assign gate   = cond_ex & bus.ValidE & !bus.FlushE;
  assign bubble = bus.StallE | bus.FlushE | !bus.ValidE;

  always_ff @(posedge clk) begin
    if (!reset) begin
      flags_q <= 4'b0000;
    end else if (go) begin
      if (bus.FlagWriteE[FW_BIT_NZ]) begin
        flags_q[FLAG_N] <= bus.ALUFlags[FLAG_N];
        flags_q[FLAG_Z] <= bus.ALUFlags[FLAG_Z];
      end
      if (bus.FlagWriteE[FW_BIT_CV]) begin
        flags_q[FLAG_C] <= bus.ALUFlags[FLAG_C];
        flags_q[FLAG_V] <= bus.ALUFlags[FLAG_V];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset || bubble) begin
      pcsrc_m_q    <= 1'b0;
      regwrite_m_q <= 1'b0;
      memwrite_m_q <= 1'b0;
      condex_m_q   <= 1'b0;
    end else begin
      pcsrc_m_q    <= bus.PCSrcE    & gate;
      regwrite_m_q <= bus.RegWriteE & gate;
      memwrite_m_q <= bus.MemWriteE & gate;
      condex_m_q   <= cond_ex;
    end
  end

  assign bus.Flags      = flags_q;
  assign bus.CarryOut   = flags_q[FLAG_C];
  assign bus.CondExE    = cond_ex;
  assign bus.PCSrcGE    = bus.PCSrcE    & gate;
  assign bus.RegWriteGE = bus.RegWriteE & gate;
  assign bus.MemWriteGE = bus.MemWriteE & gate;
  assign bus.PCSrcM     = pcsrc_m_q;
  assign bus.RegWriteM  = regwrite_m_q;
  assign bus.MemWriteM  = memwrite_m_q;
  assign bus.CondExM    = condex_m_q;

`ifdef COND_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      ExecCnt   <= '0;
      SquashCnt <= '0;
    end else begin
      if (go)
        ExecCnt <= ExecCnt + 1'b1;
      if (live & !cond_ex)
        SquashCnt <= SquashCnt + 1'b1;
    end
  end
`endif

endmodule
